// File: rtl/cmd_master_pkg.sv
// rtl/cmd_master_pkg.sv - Command encodings, FSM states and control-register addresses for cmd_master
package cmd_master_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE = 2'b00,
      CMD_RD   = 2'b01,
      CMD_WR   = 2'b10
   } cmd_e;

   typedef enum logic [2:0] {
      ST_BOOT,
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } state_e;

   localparam logic [5:0] SLV0_CTRL_ADDR = 6'h00;
   localparam logic [5:0] SLV1_CTRL_ADDR = 6'h04;
   localparam logic [5:0] SLV2_CTRL_ADDR = 6'h08;

endpackage

// File: rtl/cmd_master.sv
// rtl/cmd_master.sv - Register-bus initiator with one-cycle command issue; boot replay under CMD_MASTER_BOOT_EN
module cmd_master
   import cmd_master_pkg::*;
#(
   parameter int unsigned RD_LAT    = 1,
   parameter logic [31:0] BOOT_CFG0 = 32'h0000_0001,
   parameter logic [31:0] BOOT_CFG1 = 32'h0000_0013,
   parameter logic [31:0] BOOT_CFG2 = 32'h0000_001F
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wr_i,
   input  logic [5:0]  req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic [1:0]  cmd_o,
   output logic [5:0]  cmd_addr_o,
   output logic [31:0] cmd_data_o,
   input  logic [31:0] cmd_data_i
);

   // WAIT lasts RD_LAT cycles; the counter is loaded with RD_LAT-1 and data is taken at zero
   localparam logic [1:0] LAT_M1 = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

`ifdef CMD_MASTER_BOOT_EN
   localparam state_e RESET_STATE = ST_BOOT;
   // Entry 3 is a spacer slot so req_ready_o rises only after the third write has left the bus
   localparam logic [5:0]  BOOT_ADDR [4] = '{SLV0_CTRL_ADDR, SLV1_CTRL_ADDR, SLV2_CTRL_ADDR, 6'h00};
   localparam logic [31:0] BOOT_DATA [4] = '{BOOT_CFG0, BOOT_CFG1, BOOT_CFG2, 32'h0};
   logic [1:0] boot_idx_q, boot_idx_d;
`else
   localparam state_e RESET_STATE = ST_IDLE;
`endif

   state_e      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        req_ready_d, rsp_valid_d;
   logic [31:0] rsp_rdata_d;
   cmd_e        cmd_d;
   logic [5:0]  cmd_addr_d;
   logic [31:0] cmd_data_d;

   // State and registered outputs; reset discards any in-flight request or response
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q     <= RESET_STATE;
         cnt_q       <= '0;
         req_ready_o <= 1'b0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         cmd_o       <= CMD_IDLE;
         cmd_addr_o  <= '0;
         cmd_data_o  <= '0;
`ifdef CMD_MASTER_BOOT_EN
         boot_idx_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_o <= req_ready_d;
         rsp_valid_o <= rsp_valid_d;
         rsp_rdata_o <= rsp_rdata_d;
         cmd_o       <= cmd_d;
         cmd_addr_o  <= cmd_addr_d;
         cmd_data_o  <= cmd_data_d;
`ifdef CMD_MASTER_BOOT_EN
         boot_idx_q  <= boot_idx_d;
`endif
      end
   end

   // Next state and next output values; the command bus is idle unless a command is launched
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_ready_d = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_o;
      cmd_d       = CMD_IDLE;
      cmd_addr_d  = '0;
      cmd_data_d  = '0;
`ifdef CMD_MASTER_BOOT_EN
      boot_idx_d  = boot_idx_q;
`endif
      case (state_q)
         ST_BOOT: begin
`ifdef CMD_MASTER_BOOT_EN
            if (boot_idx_q == 2'd3) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
            end else begin
               cmd_d      = CMD_WR;
               cmd_addr_d = BOOT_ADDR[boot_idx_q];
               cmd_data_d = BOOT_DATA[boot_idx_q];
               boot_idx_d = boot_idx_q + 2'd1;
            end
`else
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
`endif
         end
         ST_IDLE: begin
            if (req_valid_i && req_ready_o) begin
               state_d    = ST_ISSUE;
               cmd_d      = req_wr_i ? CMD_WR : CMD_RD;
               cmd_addr_d = req_addr_i;
               cmd_data_d = req_wr_i ? req_wdata_i : 32'h0;
            end else begin
               req_ready_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (cmd_o == CMD_WR) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
            end else if (RD_LAT == 0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = cmd_data_i;
            end else begin
               state_d = ST_WAIT;
               cnt_d   = LAT_M1;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = cmd_data_i;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               state_d     = ST_IDLE;
               req_ready_d = 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d = RESET_STATE;
         end
      endcase
   end

endmodule

// File: tb/tb_cmd_master.sv
// tb/tb_cmd_master.sv - Randomized self-checking bench for cmd_master at RD_LAT 0..3 (boot checks under CMD_MASTER_BOOT_EN)
module tb_cmd_master;

   logic        clk = 1'b0;
   logic        rstn;
   logic        env_init;
   logic        req_valid [4];
   logic        req_ready [4];
   logic        req_wr    [4];
   logic [5:0]  req_addr  [4];
   logic [31:0] req_wdata [4];
   logic        rsp_valid [4];
   logic        rsp_ready [4];
   logic [31:0] rsp_rdata [4];
   logic [1:0]  cmd       [4];
   logic [5:0]  cmd_addr  [4];
   logic [31:0] cmd_wdata [4];
   logic [31:0] cmd_rdata [4];

   // Transaction-level picture of each lane's register block
   logic [31:0] model_mem [4][64];

   int checks = 0;
   int errors = 0;
   int cur_lane = 0;

`ifdef CMD_MASTER_BOOT_EN
   logic [5:0]  boot_a [3];
   logic [31:0] boot_d [3];
`endif

   always #5 clk = ~clk;

   // One DUT per read latency, each with its own behavioural register block
   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [31:0] mem [64];
      logic [31:0] rd_now;

      cmd_master #(.RD_LAT(g)) u_dut (
         .clk_i       (clk),
         .rstn_i      (rstn),
         .req_valid_i (req_valid[g]),
         .req_ready_o (req_ready[g]),
         .req_wr_i    (req_wr[g]),
         .req_addr_i  (req_addr[g]),
         .req_wdata_i (req_wdata[g]),
         .rsp_valid_o (rsp_valid[g]),
         .rsp_ready_i (rsp_ready[g]),
         .rsp_rdata_o (rsp_rdata[g]),
         .cmd_o       (cmd[g]),
         .cmd_addr_o  (cmd_addr[g]),
         .cmd_data_o  (cmd_wdata[g]),
         .cmd_data_i  (cmd_rdata[g])
      );

      // Read data is only meaningful in the one cycle the DUT should sample it
      assign rd_now = (cmd[g] == 2'b01) ? mem[cmd_addr[g]] : 32'hDEAD_BEEF;

      // Register block storage: every address powers up holding its own address value
      always @(posedge clk) begin
         if (env_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= {26'b0, 6'(i)};
         end else if (cmd[g] == 2'b10) begin
            mem[cmd_addr[g]] <= cmd_wdata[g];
         end
      end

      if (g == 0) begin : g_comb
         assign cmd_rdata[g] = rd_now;
      end else begin : g_pipe
         logic [31:0] pipe [1:3];
         // Delays read data so it is valid exactly RD_LAT cycles after the command cycle
         always @(posedge clk) begin
            pipe[1] <= rd_now;
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
         end
         assign cmd_rdata[g] = pipe[g];
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s lane=%0d got=%h exp=%h t=%0t", tag, cur_lane, got, exp, $time);
      end
   endtask

   task automatic chk_reset_vals(input int l);
      chk("rst_req_ready", 32'(req_ready[l]), 0);
      chk("rst_rsp_valid", 32'(rsp_valid[l]), 0);
      chk("rst_rsp_rdata", rsp_rdata[l], 0);
      chk("rst_cmd", 32'(cmd[l]), 0);
      chk("rst_cmd_addr", 32'(cmd_addr[l]), 0);
      chk("rst_cmd_data", cmd_wdata[l], 0);
   endtask

   task automatic wait_ready(input int l);
      int n = 0;
      while (req_ready[l] !== 1'b1 && n < 16) begin
         tick;
         n++;
      end
      chk("ready_seen", 32'(req_ready[l]), 1);
   endtask

   // Releases reset with a write held valid; it must be taken on the first ready cycle and no earlier
   task automatic release_seq(input int l);
      logic [31:0] d;
      d = $urandom;
      req_valid[l] = 1'b1;
      req_wr[l]    = 1'b1;
      req_addr[l]  = 6'h3C;
      req_wdata[l] = d;
      rsp_ready[l] = 1'b1;
      rstn = 1'b1;
`ifdef CMD_MASTER_BOOT_EN
      for (int c = 0; c < 3; c++) begin
         tick;
         chk("boot_cmd", 32'(cmd[l]), 2);
         chk("boot_addr", 32'(cmd_addr[l]), 32'(boot_a[c]));
         chk("boot_data", cmd_wdata[l], boot_d[c]);
         chk("boot_ready", 32'(req_ready[l]), 0);
         model_mem[l][boot_a[c]] = boot_d[c];
      end
`endif
      tick;
      chk("first_ready", 32'(req_ready[l]), 1);
      chk("first_cmd", 32'(cmd[l]), 0);
      chk("first_rsp", 32'(rsp_valid[l]), 0);
      tick;
      req_valid[l] = 1'b0;
      chk("held_cmd", 32'(cmd[l]), 2);
      chk("held_addr", 32'(cmd_addr[l]), 32'h3C);
      chk("held_data", cmd_wdata[l], d);
      model_mem[l][6'h3C] = d;
      tick;
      chk("held_ready_back", 32'(req_ready[l]), 1);
   endtask

   task automatic do_write(input int l, input logic [5:0] a, input logic [31:0] d);
      req_valid[l] = 1'b1;
      req_wr[l]    = 1'b1;
      req_addr[l]  = a;
      req_wdata[l] = d;
      wait_ready(l);
      tick;
      req_valid[l] = 1'b0;
      req_addr[l]  = 6'($urandom);
      req_wdata[l] = $urandom;
      chk("wr_cmd", 32'(cmd[l]), 2);
      chk("wr_addr", 32'(cmd_addr[l]), 32'(a));
      chk("wr_data", cmd_wdata[l], d);
      chk("wr_busy", 32'(req_ready[l]), 0);
      chk("wr_no_rsp", 32'(rsp_valid[l]), 0);
      model_mem[l][a] = d;
      tick;
      chk("wr_cmd_end", 32'(cmd[l]), 0);
      chk("wr_ready_back", 32'(req_ready[l]), 1);
      chk("wr_no_rsp2", 32'(rsp_valid[l]), 0);
   endtask

   // Read with bp cycles of response backpressure; response must land RD_LAT+2 cycles after handshake
   task automatic do_read(input int l, input logic [5:0] a, input int bp);
      logic [31:0] exp;
      exp = model_mem[l][a];
      req_valid[l] = 1'b1;
      req_wr[l]    = 1'b0;
      req_addr[l]  = a;
      req_wdata[l] = $urandom;
      rsp_ready[l] = (bp == 0);
      wait_ready(l);
      tick;
      req_valid[l] = 1'b0;
      chk("rd_cmd", 32'(cmd[l]), 1);
      chk("rd_addr", 32'(cmd_addr[l]), 32'(a));
      chk("rd_data_zero", cmd_wdata[l], 0);
      for (int j = 1; j <= l + 1; j++) begin
         chk("rd_early_rsp", 32'(rsp_valid[l]), 0);
         chk("rd_busy", 32'(req_ready[l]), 0);
         if (j > 1) chk("rd_wait_cmd", 32'(cmd[l]), 0);
         tick;
      end
      for (int k = 0; k < bp; k++) begin
         chk("bp_valid", 32'(rsp_valid[l]), 1);
         chk("bp_rdata", rsp_rdata[l], exp);
         chk("bp_busy", 32'(req_ready[l]), 0);
         chk("bp_cmd", 32'(cmd[l]), 0);
         tick;
      end
      rsp_ready[l] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid[l]), 1);
      chk("rsp_rdata", rsp_rdata[l], exp);
      tick;
      chk("rsp_done", 32'(rsp_valid[l]), 0);
      chk("rsp_ready_back", 32'(req_ready[l]), 1);
   endtask

   task automatic reset_seq(input int l);
      req_valid[l] = 1'b0;
      rsp_ready[l] = 1'b1;
      rstn = 1'b0;
      tick;
      chk_reset_vals(l);
      tick;
      chk_reset_vals(l);
   endtask

   task automatic run_lane(input int l);
      cur_lane = l;
      reset_seq(l);
      release_seq(l);
      do_write(l, 6'h00, 32'h01);
      do_write(l, 6'h04, 32'h13);
      do_write(l, 6'h08, 32'h1F);
      do_write(l, 6'h00, 32'h3F);
      do_read(l, 6'h00, 0);
      chk("raw_value", rsp_rdata[l], 32'h3F);
      do_read(l, 6'h14, 0);
      chk("addr_echo", rsp_rdata[l], 32'h14);
      do_read(l, 6'h08, 5);
      for (int t = 0; t < 30; t++) begin
         logic [5:0] a;
         a = 6'($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 1) == 1) do_write(l, a, $urandom);
         else do_read(l, a, $urandom_range(0, 3));
      end
      // Abort a read two cycles after its handshake; its response must never appear
      req_valid[l] = 1'b1;
      req_wr[l]    = 1'b0;
      req_addr[l]  = 6'h14;
      rsp_ready[l] = 1'b1;
      wait_ready(l);
      tick;
      req_valid[l] = 1'b0;
      tick;
      rstn = 1'b0;
      tick;
      chk_reset_vals(l);
      release_seq(l);
      for (int c = 0; c < 6; c++) begin
         tick;
         chk("abort_no_rsp", 32'(rsp_valid[l]), 0);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog lane=%0d checks=%0d", cur_lane, checks);
      $fatal(1);
   end

   initial begin
`ifdef CMD_MASTER_BOOT_EN
      boot_a[0] = 6'h00; boot_a[1] = 6'h04; boot_a[2] = 6'h08;
      boot_d[0] = 32'h01; boot_d[1] = 32'h13; boot_d[2] = 32'h1F;
`endif
      for (int l = 0; l < 4; l++) begin
         req_valid[l] = 1'b0;
         req_wr[l]    = 1'b0;
         req_addr[l]  = '0;
         req_wdata[l] = '0;
         rsp_ready[l] = 1'b1;
         for (int a = 0; a < 64; a++) model_mem[l][a] = {26'b0, 6'(a)};
      end
      rstn     = 1'b0;
      env_init = 1'b1;
      repeat (2) tick;
      env_init = 1'b0;
      for (int l = 0; l < 4; l++) run_lane(l);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
